// File: rtl/uart_frame_encoder_pkg.sv
// Shared definitions for the coprocessor command frame encoder.
// Frame layout: header (command code), 16 payload bytes MSB-first, tail (= header).
// The optional inter-frame gap is enabled by defining UART_FRAME_GAP_EN.
package uart_frame_encoder_pkg;

   localparam int unsigned FRAME_BYTES_DEF   = 18;
   localparam int unsigned PAYLOAD_BYTES_DEF = 16;
   localparam int unsigned BYTE_W            = 8;
   localparam int unsigned PAYLOAD_W         = PAYLOAD_BYTES_DEF * BYTE_W;
   localparam int unsigned IDX_W             = 4;

   // Command codes understood by the far-end decoder
   localparam logic [BYTE_W-1:0] CMD_TEST     = 8'h41;  // "A"
   localparam logic [BYTE_W-1:0] CMD_READ_ENC = 8'h42;  // "B"
   localparam logic [BYTE_W-1:0] CMD_KEY      = 8'h43;  // "C"
   localparam logic [BYTE_W-1:0] CMD_TEXT     = 8'h44;  // "D"
   localparam logic [BYTE_W-1:0] CMD_LOAD     = 8'h45;  // "E"

   // ST_GAP only exists in builds with UART_FRAME_GAP_EN
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEAD    = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_TAIL    = 3'd3,
      ST_GAP     = 3'd4
   } enc_state_e;

   // Payload byte i, counted from the most significant end (i=0 -> [127:120]).
   // For a 4-bit index, 15-i is simply ~i.
   function automatic logic [BYTE_W-1:0] payload_byte(input logic [PAYLOAD_W-1:0] p,
                                                      input logic [IDX_W-1:0]     i);
      return p[{~i, 3'b000} +: BYTE_W];
   endfunction

endpackage

// File: rtl/uart_frame_encoder.sv
// uart_frame_encoder: accepts one command (code + 128-bit payload) and emits it as
// an 18-byte frame (code, payload[127:120] .. payload[7:0], code) to a UART TX core
// over a valid/ready byte interface.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_code[7:0], cmd_payload    command header byte and payload, sampled on accept
//   tx_byte_valid/tx_byte_ready   byte handshake towards the UART transmitter
//   tx_byte[7:0]                  byte to transmit
//   busy                          frame in progress
//   frames_sent[CNT_W-1:0]        completed frames, wrapping
// Build option: UART_FRAME_GAP_EN inserts GAP_CYCLES idle cycles after each tail byte.
module uart_frame_encoder
   import uart_frame_encoder_pkg::*;
#(
   parameter int unsigned FRAME_BYTES   = FRAME_BYTES_DEF,
   parameter int unsigned PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
   parameter int unsigned GAP_CYCLES    = 1024,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [7:0]           cmd_code,
   input  logic [127:0]         cmd_payload,
   output logic                 tx_byte_valid,
   input  logic                 tx_byte_ready,
   output logic [7:0]           tx_byte,
   output logic                 busy,
   output logic [CNT_W-1:0]     frames_sent
);

   // Frame geometry is fixed; reject any other configuration at elaboration
   generate
      if (FRAME_BYTES != FRAME_BYTES_DEF || PAYLOAD_BYTES != FRAME_BYTES - 2 ||
          GAP_CYCLES == 0 || CNT_W == 0) begin : g_bad_cfg
         $error("uart_frame_encoder: unsupported frame configuration");
      end
   endgenerate

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

   enc_state_e             state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [BYTE_W-1:0]      code_q, code_d;
   logic [PAYLOAD_W-1:0]   payload_q, payload_d;
   logic [CNT_W-1:0]       frames_d;
   logic                   cmd_ready_d;
   logic                   tx_byte_valid_d;
   logic [BYTE_W-1:0]      tx_byte_d;
   logic                   busy_d;

`ifdef UART_FRAME_GAP_EN
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   logic [GAP_W-1:0]       gap_q, gap_d;
`endif

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         code_q        <= '0;
         payload_q     <= '0;
         frames_sent   <= '0;
         cmd_ready     <= 1'b0;
         tx_byte_valid <= 1'b0;
         tx_byte       <= 8'h00;
         busy          <= 1'b0;
`ifdef UART_FRAME_GAP_EN
         gap_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         code_q        <= code_d;
         payload_q     <= payload_d;
         frames_sent   <= frames_d;
         cmd_ready     <= cmd_ready_d;
         tx_byte_valid <= tx_byte_valid_d;
         tx_byte       <= tx_byte_d;
         busy          <= busy_d;
`ifdef UART_FRAME_GAP_EN
         gap_q         <= gap_d;
`endif
      end
   end

   // Next state; outputs are decoded from the next state so they register in step with it
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      code_d          = code_q;
      payload_d       = payload_q;
      frames_d        = frames_sent;
      cmd_ready_d     = 1'b0;
      tx_byte_valid_d = 1'b0;
      tx_byte_d       = 8'h00;
      busy_d          = 1'b0;
`ifdef UART_FRAME_GAP_EN
      gap_d           = gap_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               code_d    = cmd_code;
               payload_d = cmd_payload;
               state_d   = ST_HEAD;
            end
         end
         ST_HEAD: begin
            if (tx_byte_ready) begin
               idx_d   = '0;
               state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (tx_byte_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_TAIL;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_TAIL: begin
            if (tx_byte_ready) begin
               frames_d = frames_sent + CNT_W'(1);
`ifdef UART_FRAME_GAP_EN
               gap_d    = GAP_W'(GAP_CYCLES - 1);
               state_d  = ST_GAP;
`else
               state_d  = ST_IDLE;
`endif
            end
         end
`ifdef UART_FRAME_GAP_EN
         ST_GAP: begin
            if (gap_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);

      unique case (state_d)
         ST_HEAD, ST_TAIL: begin
            tx_byte_valid_d = 1'b1;
            tx_byte_d       = code_d;
         end
         ST_PAYLOAD: begin
            tx_byte_valid_d = 1'b1;
            tx_byte_d       = payload_byte(payload_d, idx_d);
         end
         default: begin
            tx_byte_valid_d = 1'b0;
            tx_byte_d       = 8'h00;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_frame_encoder.sv
// Directed self-checking bench for uart_frame_encoder.
// The counter is instantiated 4 bits wide so wrap-around is reached in a few frames.
module tb_uart_frame_encoder;

   localparam int unsigned CNT_W_TB = 4;
   localparam int unsigned GAP_TB   = 8;
`ifdef UART_FRAME_GAP_EN
   localparam int EXP_GAP = 8;
`else
   localparam int EXP_GAP = 0;
`endif

   logic                clk = 1'b0;
   logic                reset_n;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [7:0]          cmd_code;
   logic [127:0]        cmd_payload;
   logic                tx_byte_valid;
   logic                tx_byte_ready;
   logic [7:0]          tx_byte;
   logic                busy;
   logic [CNT_W_TB-1:0] frames_sent;

   int vectors = 0;
   int errors  = 0;
   int exp_frames = 0;

   uart_frame_encoder #(
      .GAP_CYCLES (GAP_TB),
      .CNT_W      (CNT_W_TB)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_code      (cmd_code),
      .cmd_payload   (cmd_payload),
      .tx_byte_valid (tx_byte_valid),
      .tx_byte_ready (tx_byte_ready),
      .tx_byte       (tx_byte),
      .busy          (busy),
      .frames_sent   (frames_sent)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Byte k of the frame: code, payload bytes MSB first, code
   function automatic logic [7:0] exp_byte(input logic [7:0] c, input logic [127:0] p, input int k);
      logic [127:0] t;
      if (k == 0 || k == 17) return c;
      t = p << (8 * (k - 1));
      return t[127:120];
   endfunction

   // Called at a negedge in IDLE; leaves us at the negedge after acceptance
   task automatic start_cmd(input logic [7:0] c, input logic [127:0] p, input bit hold);
      check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid   = 1'b1;
      cmd_code    = c;
      cmd_payload = p;
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      check("first_byte_latency", 32'(tx_byte_valid), 32'd1);
      check("busy_in_frame", 32'(busy), 32'd1);
      check("cmd_ready_in_frame", 32'(cmd_ready), 32'd0);
   endtask

   // Accept the 18 bytes; mode 1 raises ready on one cycle out of three
   task automatic drain(input logic [7:0] c, input logic [127:0] p, input int mode, output int cycles);
      int n;
      logic rdy;
      n = 0;
      cycles = 0;
      while (n < 18 && cycles < 300) begin
         rdy = (mode == 1) ? (cycles % 3 == 2) : 1'b1;
         check("tx_valid_in_frame", 32'(tx_byte_valid), 32'd1);
         check("tx_byte", 32'(tx_byte), 32'(exp_byte(c, p, n)));
         tx_byte_ready = rdy;
         if (rdy) n++;
         @(negedge clk);
         cycles++;
      end
      tx_byte_ready = 1'b0;
      check("drain_byte_count", 32'(n), 32'd18);
      exp_frames++;
      check("frames_sent", 32'(frames_sent), 32'(exp_frames % (1 << CNT_W_TB)));
   endtask

   // Count cycles with cmd_ready low after the tail byte was accepted
   task automatic wait_gap();
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 40) begin
         check("gap_tx_valid_low", 32'(tx_byte_valid), 32'd0);
         @(negedge clk);
         n++;
      end
      check("gap_cycles", 32'(n), 32'(EXP_GAP));
      check("idle_busy_low", 32'(busy), 32'd0);
      check("idle_tx_valid_low", 32'(tx_byte_valid), 32'd0);
   endtask

   initial begin
      logic [127:0] p_inc, p1, p2, pw;
      int           cyc;
      p_inc = 128'h000102030405060708090A0B0C0D0E0F;
      p1    = 128'hDEADBEEFCAFEF00D1122334455667788;
      p2    = 128'h0123456789ABCDEFFEDCBA9876543210;

      reset_n       = 1'b0;
      cmd_valid     = 1'b0;
      cmd_code      = 8'h00;
      cmd_payload   = '0;
      tx_byte_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_tx_valid", 32'(tx_byte_valid), 32'd0);
      check("rst_tx_byte", 32'(tx_byte), 32'h00);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frames", 32'(frames_sent), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Abort after 7 bytes with reset; counter stays 0, no tail
      start_cmd(8'h41, p_inc, 1'b0);
      tx_byte_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         check("abort_pre_byte", 32'(tx_byte), 32'(exp_byte(8'h41, p_inc, k)));
         @(negedge clk);
      end
      #2 reset_n = 1'b0;
      #1;
      check("abort_tx_valid", 32'(tx_byte_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_frames", 32'(frames_sent), 32'd0);
      tx_byte_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Full frame, ready always high: 18 consecutive cycles
      start_cmd(8'h41, p_inc, 1'b0);
      drain(8'h41, p_inc, 0, cyc);
      check("back_to_back_cycles", 32'(cyc), 32'd18);
      wait_gap();

      // Stalled transmitter: bytes held stable, nothing dropped or repeated
      start_cmd(8'h43, p_inc, 1'b0);
      drain(8'h43, p_inc, 1, cyc);
      check("stalled_cycles", 32'(cyc), 32'd54);
      wait_gap();

      // Command held with new contents during a frame: only taken in IDLE
      start_cmd(8'h42, p1, 1'b1);
      cmd_code    = 8'h45;
      cmd_payload = p2;
      drain(8'h42, p1, 0, cyc);
      wait_gap();
      start_cmd(8'h45, p2, 1'b0);
      drain(8'h45, p2, 0, cyc);
      wait_gap();

      // Counter wrap: 11 more frames reach 4'hF, one more wraps to 0 (includes code 8'h00)
      for (int i = 0; i < 12; i++) begin
         pw = {4{32'(i) * 32'h01010101 ^ 32'hA5C30F96}};
         start_cmd(8'(i * 17), pw, 1'b0);
         drain(8'(i * 17), pw, 0, cyc);
         if (i == 10) check("frames_at_max", 32'(frames_sent), 32'hF);
         if (i == 11) check("frames_wrapped", 32'(frames_sent), 32'h0);
         wait_gap();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
